i2c_frequency_generator: RTL and testbench
==========================================

Name: i2c_frequency_generator

Overview:
Programmable successor to the fixed-value I2C frequency selector. It holds the active I2C prescale setting, which software can reconfigure at runtime through preset modes or a custom value. New settings are committed only while the I2C bus is idle. The block also generates the prescaled enable tick (5 ticks per SCL period) consumed by the I2C master core on the 160 MHz wishbone clock.

Parameters:
FREQ_SELECTION_BIT_WIDTH, 16, width of the prescale setting and the tick counter
DEFAULT_SETTING, 'h013f, setting after reset (100 kHz at 160 MHz)
MIN_SETTING, 3, smallest legal setting; custom values below it are rejected

Ports:
clk_i  in  1  wishbone clock, 160 MHz
rst_i  in  1  reset, synchronous, active-high
cfg_valid_i  in  1  configuration request
cfg_ready_o  out  1  request accepted when valid and ready are both high in a cycle
cfg_mode_i  in  3  0=100k ('h013f), 1=400k ('h004f), 2=1M ('h001f), 3=sim 8M ('h0003), 4=custom, 5-7 reserved
cfg_custom_i  in  FREQ_SELECTION_BIT_WIDTH  setting used when mode is 4
bus_busy_i  in  1  I2C master is mid-transfer; no setting change allowed
tick_en_i  in  1  enables the tick counter
frequency_setting_o  out  FREQ_SELECTION_BIT_WIDTH  active setting = (f_wb / (5*f_scl)) - 1
tick_o  out  1  one-cycle pulse every frequency_setting_o+1 enabled cycles
pending_o  out  1  accepted setting is waiting for the bus to go idle
applied_o  out  1  one-cycle pulse when a pending setting is committed
cfg_error_o  out  1  one-cycle pulse when a request is rejected

Behaviour:
- All outputs are registered. Reset state:
  - frequency_setting_o=DEFAULT_SETTING, counter=DEFAULT_SETTING
  - tick_o=0, pending_o=0, applied_o=0, cfg_error_o=0, cfg_ready_o=1
- FSM states: IDLE, PENDING.
  - IDLE: cfg_ready_o=1.
  - PENDING: cfg_ready_o=0. Requests are not accepted, and the source holds them.
- Accept (IDLE, cfg_valid_i=1, cycle N):
  - Illegal request (mode 5-7, or mode 4 with cfg_custom_i < MIN_SETTING): cfg_error_o=1 in cycle N+1 only. State and setting are unchanged.
  - Legal request: the resolved value is stored in pending_r. State goes to PENDING, so pending_o=1 and cfg_ready_o=0 from cycle N+1.
- Commit (PENDING, bus_busy_i=0 sampled in cycle M):
  - In cycle M+1: frequency_setting_o=pending_r, counter reloaded with pending_r, applied_o=1 for one cycle, tick_o=0, pending_o=0.
  - State returns to IDLE, so cfg_ready_o=1 in cycle M+1.
  - Fastest path: bus idle at acceptance gives setting visible in cycle N+2.
- While bus_busy_i=1 in PENDING, the commit is deferred indefinitely. The old setting and tick cadence continue unaltered.
- A request whose resolved value equals the current setting is still treated as legal: full PENDING/commit sequence, applied_o pulses, counter reloaded.
- Tick counter (non-commit cycles):
  - tick_en_i=0: counter<=frequency_setting_o, tick_o<=0.
  - tick_en_i=1 and counter==0: counter<=frequency_setting_o, tick_o<=1.
  - tick_en_i=1 and counter!=0: counter<=counter-1, tick_o<=0.
  - Result: with enable rising at cycle 0, the first tick_o is in cycle S+1, then every S+1 cycles, where S=frequency_setting_o.
- Commit has priority over the counter. The reload uses the new value and suppresses any tick due in that cycle, so a tick period never mixes the old and new setting.
- Dropping tick_en_i mid-period discards the partial count. No tick is emitted.
- The counter is FREQ_SELECTION_BIT_WIDTH wide with no wrap-around. Because S >= MIN_SETTING always holds, the minimum tick period is 4 cycles.
- rst_i asserted in any state, including PENDING, discards pending_r and restores the reset state on the next edge.

Test Plan:
- Reset -> frequency_setting_o='h013f, cfg_ready_o=1, pending_o=0; with tick_en_i=1, tick_o pulses every 320 cycles, first pulse at cycle 320.
- cfg_mode_i=1 accepted at cycle N, bus_busy_i=0 -> cycle N+1: pending_o=1, cfg_ready_o=0; cycle N+2: frequency_setting_o='h004f, applied_o=1; ticks then every 80 cycles, no tick in the commit cycle.
- bus_busy_i=1 held 100 cycles, mode 4 custom 'h0009 requested -> pending_o=1 for the whole window, old 320-cycle cadence intact, cfg_valid_i ignored; busy drops at cycle M -> setting 'h0009 in M+1, tick period 10.
- cfg_mode_i=6, then mode 4 with custom 'h0002 -> cfg_error_o single-cycle pulse each time, setting stays 'h013f, cfg_ready_o stays 1, applied_o never asserts.
- Mode 3 request, then tick_en_i toggled low mid-period -> no tick emitted and counter reloaded; re-enable gives the first tick 4 cycles later, period 4.
- rst_i in PENDING with busy high -> next cycle pending_o=0, setting 'h013f; bus release afterwards causes no commit and no applied_o.

Source files
------------

// File: rtl/i2c_frequency_generator.sv
// i2c_frequency_generator: runtime-programmable I2C prescale setting plus the prescaled enable tick
// Ports:
//   clk_i, rst_i                     wishbone clock, synchronous active-high reset
//   cfg_valid_i/cfg_ready_o          configuration handshake
//   cfg_mode_i, cfg_custom_i         preset selector and custom setting for mode 4
//   bus_busy_i                       holds a pending setting until the bus goes idle
//   tick_en_i, tick_o                counter enable and one-cycle tick every setting+1 enabled cycles
//   frequency_setting_o              active setting
//   pending_o, applied_o, cfg_error_o  status: waiting, committed pulse, rejected pulse
module i2c_frequency_generator #(
    parameter int FREQ_SELECTION_BIT_WIDTH = 16,
    parameter logic [FREQ_SELECTION_BIT_WIDTH-1:0] DEFAULT_SETTING = 'h013f,
    parameter int MIN_SETTING = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cfg_valid_i,
    output logic                                cfg_ready_o,
    input  logic [2:0]                          cfg_mode_i,
    input  logic [FREQ_SELECTION_BIT_WIDTH-1:0] cfg_custom_i,
    input  logic                                bus_busy_i,
    input  logic                                tick_en_i,
    output logic [FREQ_SELECTION_BIT_WIDTH-1:0] frequency_setting_o,
    output logic                                tick_o,
    output logic                                pending_o,
    output logic                                applied_o,
    output logic                                cfg_error_o
);
    localparam int W = FREQ_SELECTION_BIT_WIDTH;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    logic [0:0]   state;
    logic [W-1:0] pending_r;
    logic [W-1:0] counter;
    logic [W-1:0] resolved;
    logic         legal;
    logic         commit;

    always_comb begin
        resolved = cfg_mode_i == 3'd0 ? W'('h013f) :
                   cfg_mode_i == 3'd1 ? W'('h004f) :
                   cfg_mode_i == 3'd2 ? W'('h001f) :
                   cfg_mode_i == 3'd3 ? W'('h0003) : cfg_custom_i;
        legal    = cfg_mode_i <= 3'd3 || (cfg_mode_i == 3'd4 && cfg_custom_i >= W'(MIN_SETTING));
        commit   = state == PENDING && !bus_busy_i;
    end

    assign pending_o = state == PENDING;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state               <= IDLE;
            pending_r           <= DEFAULT_SETTING;
            frequency_setting_o <= DEFAULT_SETTING;
            counter             <= DEFAULT_SETTING;
            tick_o              <= 1'b0;
            applied_o           <= 1'b0;
            cfg_error_o         <= 1'b0;
            cfg_ready_o         <= 1'b1;
        end else begin
            applied_o   <= 1'b0;
            cfg_error_o <= 1'b0;
            if (commit) begin
                // reload with the new value and drop any tick due now so no period mixes settings
                state               <= IDLE;
                frequency_setting_o <= pending_r;
                counter             <= pending_r;
                tick_o              <= 1'b0;
                applied_o           <= 1'b1;
                cfg_ready_o         <= 1'b1;
            end else begin
                counter <= tick_en_i && counter != '0 ? counter - 1'b1 : frequency_setting_o;
                tick_o  <= tick_en_i && counter == '0;
                if (state == IDLE && cfg_valid_i) begin
                    if (legal) begin
                        state       <= PENDING;
                        pending_r   <= resolved;
                        cfg_ready_o <= 1'b0;
                    end else begin
                        cfg_error_o <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_frequency_generator.sv
// tb_i2c_frequency_generator: directed and randomized checks against a cycle-level reference model
module tb_i2c_frequency_generator;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic [2:0]   cfg_mode = '0;
    logic [W-1:0] cfg_custom = '0;
    logic         bus_busy = 1'b0;
    logic         tick_en = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] setting;
    logic         tick;
    logic         pending;
    logic         applied;
    logic         cfg_error;

    i2c_frequency_generator dut (
        .clk_i(clk),
        .rst_i(rst),
        .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready),
        .cfg_mode_i(cfg_mode),
        .cfg_custom_i(cfg_custom),
        .bus_busy_i(bus_busy),
        .tick_en_i(tick_en),
        .frequency_setting_o(setting),
        .tick_o(tick),
        .pending_o(pending),
        .applied_o(applied),
        .cfg_error_o(cfg_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // reference model: setting, pending request, enabled cycles elapsed since the last reload or tick
    int m_set = 'h013f;
    int m_pval = 0;
    int m_run = 0;
    bit m_pend = 0;
    bit m_tick = 0;
    bit m_app = 0;
    bit m_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int resolve(input int mode, input int custom);
        int presets[4] = '{320, 80, 32, 4};
        if (mode < 4) return presets[mode] - 1;
        if (mode == 4 && custom >= 3) return custom;
        return -1;
    endfunction

    task automatic model_edge();
        int v;
        m_app = 0;
        m_err = 0;
        if (rst) begin
            m_set = 'h013f; m_pend = 0; m_run = 0; m_tick = 0;
        end else if (m_pend && !bus_busy) begin
            m_set = m_pval; m_pend = 0; m_run = 0; m_tick = 0; m_app = 1;
        end else begin
            if (tick_en) begin
                m_run++;
                m_tick = m_run == m_set + 1;
                if (m_tick) m_run = 0;
            end else begin
                m_run = 0; m_tick = 0;
            end
            if (!m_pend && cfg_valid) begin
                v = resolve(int'(cfg_mode), int'(cfg_custom));
                if (v < 0) m_err = 1;
                else begin m_pend = 1; m_pval = v; end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("setting", int'(setting), m_set);
        check("tick", int'(tick), int'(m_tick));
        check("pending", int'(pending), int'(m_pend));
        check("ready", int'(cfg_ready), int'(!m_pend));
        check("applied", int'(applied), int'(m_app));
        check("cfg_error", int'(cfg_error), int'(m_err));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic request(input int mode, input int custom);
        cfg_valid = 1'b1; cfg_mode = 3'(mode); cfg_custom = W'(custom);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic first_tick(input string tag, input int limit, input int exp);
        int first = 0;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (tick && first == 0) first = i;
        end
        check(tag, first, exp);
    endtask

    initial begin
        run(2);
        rst = 1'b0;
        check("rst_setting", int'(setting), 'h013f);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_pending", int'(pending), 0);

        tick_en = 1'b1;
        first_tick("first_tick_100k", 330, 320);
        run(330);

        request(1, 0);
        check("m1_pending", int'(pending), 1);
        check("m1_ready", int'(cfg_ready), 0);
        step();
        check("m1_setting", int'(setting), 'h004f);
        check("m1_applied", int'(applied), 1);
        first_tick("first_tick_400k", 85, 80);
        run(170);

        bus_busy = 1'b1;
        request(4, 9);
        for (int i = 0; i < 100; i++) begin
            cfg_valid = i[0]; cfg_mode = 3'd2;
            step();
        end
        cfg_valid = 1'b0;
        check("busy_pending", int'(pending), 1);
        check("busy_setting", int'(setting), 'h004f);
        bus_busy = 1'b0;
        step();
        check("busy_commit", int'(setting), 9);
        first_tick("first_tick_custom", 12, 10);
        run(30);

        request(6, 0);
        check("err_mode6", int'(cfg_error), 1);
        step();
        check("err_pulse_once", int'(cfg_error), 0);
        request(4, 2);
        check("err_custom2", int'(cfg_error), 1);
        check("err_setting", int'(setting), 9);
        check("err_ready", int'(cfg_ready), 1);
        run(3);

        request(3, 0);
        step();
        check("m3_setting", int'(setting), 3);
        run(2);
        tick_en = 1'b0;
        run(3);
        tick_en = 1'b1;
        first_tick("first_tick_sim", 6, 4);
        run(12);

        bus_busy = 1'b1;
        request(2, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_pend_clear", int'(pending), 0);
        check("rst_pend_setting", int'(setting), 'h013f);
        bus_busy = 1'b0;
        run(5);

        for (int i = 0; i < 4000; i++) begin
            rst = $urandom_range(0, 199) == 0;
            cfg_valid = $urandom_range(0, 3) == 0;
            cfg_mode = 3'($urandom_range(0, 7));
            cfg_custom = W'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) bus_busy = ~bus_busy;
            tick_en = $urandom_range(0, 19) != 0;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
